// File: rtl/parity_pkg.sv
// Shared constants and helpers for the parity stream generator/checker.
// Optional error counter build macro: PARITY_ERR_CNT_EN.
package parity_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_W_DEF    = 8;
  localparam int ERR_CNT_W_DEF = 16;
  localparam int MAX_DATA_W    = 64;

  // XOR of the low 'width' bits of d; callers zero-extend their word to MAX_DATA_W.
  function automatic logic xor_reduce(input logic [MAX_DATA_W-1:0] d,
                                      input int unsigned width);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < int'(width)) r = r ^ d[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational XOR reduction of a DATA_W-bit word (raw parity, no mode).
// Kept standalone so a receiver-side checker can reuse it.
module parity_tree
  import parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data,
  output logic              par
);

  logic [MAX_DATA_W-1:0] ext;

  // Zero-extend the word and fold it down to a single parity bit.
  always_comb begin
    ext              = '0;
    ext[DATA_W-1:0]  = data;
    par              = xor_reduce(ext, DATA_W);
  end

endmodule

// File: rtl/parity_stream_gen_chk.sv
// Pipelined parity generator/checker for a valid/ready word stream with
// running frame parity across beats delimited by s_last.
// Optional saturating error counter: define PARITY_ERR_CNT_EN to add the
// err_clr input and err_cnt output.
//
// Handshake: a beat transfers on any rising edge where valid && ready are both
// high. s_ready = !m_valid || m_ready (single output register, no skid buffer),
// so an accepted beat appears on m_* one cycle later. While m_valid=1 and
// m_ready=0 every m_* output holds; the source may change s_* freely while
// s_valid=0.
module parity_stream_gen_chk
  import parity_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_odd,
  input  logic              chk_mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_par,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_par,
  output logic              m_err,
  output logic              m_last,
  output logic              m_frame_par
`ifdef PARITY_ERR_CNT_EN
  ,
  input  logic              err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  // Elaboration-time sanity checks on the configuration.
  if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("parity_stream_gen_chk: DATA_W must be 1..64");
  end
  if (ERR_CNT_W < 1) begin : g_bad_cnt_w
    $error("parity_stream_gen_chk: ERR_CNT_W must be at least 1");
  end

  logic wp;        // raw XOR of the incoming word
  logic par_now;   // word parity with mode applied
  logic err_now;   // mismatch against s_par in check mode
  logic accept;
  logic acc;       // raw XOR of all earlier beats in the current frame

  parity_tree #(.DATA_W(DATA_W)) u_tree (
    .data (s_data),
    .par  (wp)
  );

  // Handshake and per-beat parity results.
  always_comb begin
    s_ready = !m_valid || m_ready;
    accept  = s_valid && s_ready;
    par_now = (mode_odd == PAR_ODD) ? ~wp : wp;
    err_now = chk_mode && (par_now != s_par);
  end

  // Output register and frame accumulator; accumulator ignores mode so a
  // mid-frame mode change only affects the beat that closes the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_par       <= 1'b0;
      m_err       <= 1'b0;
      m_last      <= 1'b0;
      m_frame_par <= 1'b0;
      acc         <= 1'b0;
    end else if (accept) begin
      m_valid     <= 1'b1;
      m_data      <= s_data;
      m_par       <= par_now;
      m_err       <= err_now;
      m_last      <= s_last;
      m_frame_par <= s_last ? (acc ^ par_now) : 1'b0;
      acc         <= s_last ? 1'b0 : (acc ^ wp);
    end else if (m_ready) begin
      m_valid     <= 1'b0;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // Saturating count of mismatching accepted beats; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (accept && err_now && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_stream_gen_chk.sv
// Self-checking bench for parity_stream_gen_chk (DATA_W=8, ERR_CNT_W=2).
// Honours PARITY_ERR_CNT_EN to exercise the optional error counter.
module tb_parity_stream_gen_chk;

  localparam int DW = 8;
  localparam int CW = 2;
  localparam int EW = DW + 4;

  logic          clk;
  logic          rst_n;
  logic          mode_odd;
  logic          chk_mode;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_par;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_par;
  logic          m_err;
  logic          m_last;
  logic          m_frame_par;
`ifdef PARITY_ERR_CNT_EN
  logic          err_clr;
  logic [CW-1:0] err_cnt;
`endif

  parity_stream_gen_chk #(.DATA_W(DW), .ERR_CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_odd    (mode_odd),
    .chk_mode    (chk_mode),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_par       (s_par),
    .s_last      (s_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_par       (m_par),
    .m_err       (m_err),
    .m_last      (m_last),
    .m_frame_par (m_frame_par)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_clr     (err_clr),
    .err_cnt     (err_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Expected beat: {data, par, err, last, frame_par}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int            frame_ones;   // number of 1 bits seen so far in the open frame
  int            ones;
  logic          mp, me, mf;
  logic          last_acc;
  logic [CW-1:0] exp_cnt;

  // Sample at the falling edge: compare the beat leaving now, then predict
  // the beat being accepted at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stream_extra: got beat data=0x%0h expected no beat at %0t", m_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("stream", 64'({m_data, m_par, m_err, m_last, m_frame_par}), 64'(mon_e));
        end
      end
      last_acc = s_valid && s_ready;
      if (last_acc) begin
        ones = $countones(s_data);
        mp   = ((ones % 2) == 1) ^ mode_odd;
        me   = chk_mode && (mp != s_par);
        mf   = s_last ? ((((frame_ones + ones) % 2) == 1) ^ mode_odd) : 1'b0;
        frame_ones = s_last ? 0 : frame_ones + ones;
        exp_q.push_back({s_data, mp, me, s_last, mf});
      end
`ifdef PARITY_ERR_CNT_EN
      if (err_clr) exp_cnt = '0;
      else if (last_acc && me && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
`endif
    end
  end

  task automatic model_reset();
    exp_q.delete();
    frame_ones = 0;
    exp_cnt    = '0;
    last_acc   = 1'b0;
  endtask

  // ---------------- stimulus records ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic          odd;
    logic          chk;
    logic          par_in;
    logic          last;
    logic          e_par;
    logic          e_err;
    logic          e_fp;
  } vec_t;

  vec_t vecs[16];
  vec_t v;

  // Drive one beat for a single cycle; outputs are readable on return.
  task automatic apply(input vec_t x);
    @(posedge clk);
    #1;
    s_data   = x.data;
    mode_odd = x.odd;
    chk_mode = x.chk;
    s_par    = x.par_in;
    s_last   = x.last;
    s_valid  = 1'b1;
    @(posedge clk);
    #1;
    s_valid  = 1'b0;
  endtask

  logic [EW:0] held;

  initial begin
    //               data   odd  chk  spar last  par  err  fp
    vecs[0]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n    = 1'b0;
    mode_odd = 1'b0;
    chk_mode = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_par    = 1'b0;
    s_last   = 1'b0;
    m_ready  = 1'b1;
`ifdef PARITY_ERR_CNT_EN
    err_clr  = 1'b0;
`endif
    model_reset();

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", 64'({m_valid, m_data, m_par, m_err, m_last, m_frame_par}), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(1));
`ifdef PARITY_ERR_CNT_EN
    check("rst_err_cnt", 64'(err_cnt), 64'(0));
`endif
    rst_n = 1'b1;

    // ---- table of single beats and short frames ----
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      check($sformatf("vec%0d", i),
            64'({m_valid, m_data, m_par, m_err, m_last, m_frame_par}),
            64'({1'b1, vecs[i].data, vecs[i].e_par, vecs[i].e_err, vecs[i].last, vecs[i].e_fp}));
`ifdef PARITY_ERR_CNT_EN
      if (i == 3) check("err_cnt_after_chk", 64'(err_cnt), 64'(1));
`endif
    end

    // ---- backpressure: hold m_ready low ----
    @(posedge clk);
    #1;
    m_ready  = 1'b0;
    s_data   = 8'h11;
    s_last   = 1'b0;
    mode_odd = 1'b0;
    chk_mode = 1'b0;
    s_valid  = 1'b1;
    @(posedge clk);
    #1;
    check("bp_first_valid", 64'({m_valid, m_data}), 64'({1'b1, 8'h11}));
    held   = {m_valid, m_data, m_par, m_err, m_last, m_frame_par};
    s_data = 8'h22;
    s_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_s_ready", 64'(s_ready), 64'(0));
      check("bp_hold", 64'({m_valid, m_data, m_par, m_err, m_last, m_frame_par}), 64'(held));
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("bp_second", 64'({m_valid, m_data, m_last}), 64'({1'b1, 8'h22, 1'b1}));
    @(posedge clk);
    #1;
    check("bp_drain_valid", 64'(m_valid), 64'(0));

    // ---- reset in the middle of a frame ----
    m_ready = 1'b0;
    v = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    apply(v);
    check("pre_rst_valid", 64'(m_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_valid", 64'(m_valid), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    v = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    apply(v);
    check("post_rst_frame_par", 64'({m_valid, m_last, m_frame_par}), 64'({1'b1, 1'b1, 1'b1}));

`ifdef PARITY_ERR_CNT_EN
    // ---- counter saturation and clear priority ----
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("cnt_cleared", 64'(err_cnt), 64'(0));
    v = '{8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) apply(v);
    check("cnt_saturated", 64'(err_cnt), 64'(3));
    err_clr = 1'b1;
    apply(v);
    err_clr = 1'b0;
    check("cnt_clear_wins", 64'(err_cnt), 64'(0));
`endif

    // ---- randomized stream with random backpressure ----
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
`ifdef PARITY_ERR_CNT_EN
      check("rand_err_cnt", 64'(err_cnt), 64'(exp_cnt));
      err_clr = ($urandom_range(0, 15) == 0);
`endif
      if (!s_valid || last_acc) begin
        s_valid  = ($urandom_range(0, 3) != 0);
        s_data   = 8'($urandom);
        s_last   = ($urandom_range(0, 3) == 0);
        mode_odd = 1'($urandom_range(0, 1));
        chk_mode = 1'($urandom_range(0, 1));
        s_par    = 1'($urandom_range(0, 1));
      end
      m_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
`ifdef PARITY_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    repeat (5) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    check("drain_valid", 64'(m_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
